// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: moves one line of BEATS x BEAT_WIDTH bits between a
// beat-serial request/data bus and a line-wide storage array. Supports variable
// burst length, critical-beat-first wrapping and per-byte write masks.

`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 32
`endif

module mem_burst_ctrl #(
  parameter int BEAT_WIDTH = 128,
  parameter int BEATS      = 4,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = `PHY_ADDR_WIDTH,
  localparam int LEN_W     = $clog2(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req_vld,
  input  logic                    i_req_wr,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [LEN_W-1:0]        i_req_len,
  output logic                    o_req_rdy,
  input  logic                    i_wdat_vld,
  input  logic [BEAT_WIDTH-1:0]   i_wdat,
  input  logic [BEAT_WIDTH/8-1:0] i_wmask,
  output logic                    o_wr_ack,
  output logic                    o_rdat_vld,
  output logic [BEAT_WIDTH-1:0]   o_rdat,
  output logic                    o_rdat_last
);

  localparam int NB     = BEAT_WIDTH / 8;     // bytes per beat
  localparam int BB     = $clog2(NB);         // byte-in-beat address bits
  localparam int IW     = $clog2(DEPTH);      // line index bits
  localparam int LINE_W = BEATS * BEAT_WIDTH; // bits per line
  localparam int LINE_B = BEATS * NB;         // bytes per line

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WCOLLECT = 3'd1;
  localparam logic [2:0] S_WCOMMIT  = 3'd2;
  localparam logic [2:0] S_RREAD    = 3'd3;
  localparam logic [2:0] S_RSEND    = 3'd4;

  logic [2:0]        state_q;
  logic [LEN_W-1:0]  off_q;    // starting beat within the line
  logic [IW-1:0]     idx_q;    // line index
  logic [LEN_W-1:0]  len_q;    // burst length minus one
  logic [LEN_W-1:0]  cnt_q;    // beat counter within the burst
  logic [LINE_B-1:0] mask_q;   // assembled byte enables for the whole line
  logic [LINE_W-1:0] wdat_q;   // assembled write line
  logic [LINE_W-1:0] line_q;   // line fetched for a read burst
  logic [LEN_W-1:0]  slot;     // line beat addressed by the current burst beat

  logic [LINE_W-1:0] mem [DEPTH];

  // Only a slice of the byte address is decoded; the remaining bits are don't-care.
  logic addr_unused;
  assign addr_unused = ^i_req_addr;

  // Beats wrap around the line: the LEN_W-bit sum drops the carry.
  assign slot = off_q + cnt_q;

  // Control FSM: request latch, beat counting, mask assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (i_req_vld) begin
            off_q   <= i_req_addr[BB +: LEN_W];
            idx_q   <= i_req_addr[BB+LEN_W +: IW];
            len_q   <= i_req_len;
            cnt_q   <= '0;
            mask_q  <= '0;  // beats not sent in this burst must not be written
            state_q <= i_req_wr ? S_WCOLLECT : S_RREAD;
          end
        end
        S_WCOLLECT: begin
          if (i_wdat_vld) begin
            mask_q[int'(slot)*NB +: NB] <= i_wmask;
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q) state_q <= S_WCOMMIT;
          end
        end
        S_WCOMMIT: state_q <= S_IDLE;
        S_RREAD:   state_q <= S_RSEND;
        S_RSEND: begin
          cnt_q <= cnt_q + LEN_W'(1);
          if (cnt_q == len_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath: write-line assembly, line fetch and byte-masked commit.
  // NOTE: storage and data staging have no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    if (state_q == S_WCOLLECT && i_wdat_vld)
      wdat_q[int'(slot)*BEAT_WIDTH +: BEAT_WIDTH] <= i_wdat;
    if (state_q == S_RREAD)
      line_q <= mem[idx_q];
    if (state_q == S_WCOMMIT) begin
      for (int b = 0; b < LINE_B; b++) begin
        if (mask_q[b]) mem[idx_q][b*8 +: 8] <= wdat_q[b*8 +: 8];
      end
    end
  end

  // Outputs decode from state and registers only; nothing flows straight from i_*.
  assign o_req_rdy   = (state_q == S_IDLE);
  assign o_wr_ack    = (state_q == S_WCOMMIT);
  assign o_rdat_vld  = (state_q == S_RSEND);
  assign o_rdat_last = (state_q == S_RSEND) && (cnt_q == len_q);
  assign o_rdat      = (state_q == S_RSEND) ? line_q[int'(slot)*BEAT_WIDTH +: BEAT_WIDTH]
                                            : '0;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: directed scenarios plus randomized
// traffic, compared against a byte-addressed reference model of the array.

module tb_mem_burst_ctrl;

  localparam int BW     = 128;
  localparam int BEATS  = 4;
  localparam int DEPTH  = 256;
  localparam int AW     = 32;
  localparam int NB     = BW / 8;
  localparam int LW     = $clog2(BEATS);
  localparam int LINE_B = NB * BEATS;
  localparam int NLINES = 8;  // lines exercised by the bench

  logic          clk;
  logic          rst_n;
  logic          i_req_vld;
  logic          i_req_wr;
  logic [AW-1:0] i_req_addr;
  logic [LW-1:0] i_req_len;
  logic          o_req_rdy;
  logic          i_wdat_vld;
  logic [BW-1:0] i_wdat;
  logic [NB-1:0] i_wmask;
  logic          o_wr_ack;
  logic          o_rdat_vld;
  logic [BW-1:0] o_rdat;
  logic          o_rdat_last;

  mem_burst_ctrl #(.BEAT_WIDTH(BW), .BEATS(BEATS), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_vld(i_req_vld), .i_req_wr(i_req_wr), .i_req_addr(i_req_addr),
    .i_req_len(i_req_len), .o_req_rdy(o_req_rdy),
    .i_wdat_vld(i_wdat_vld), .i_wdat(i_wdat), .i_wmask(i_wmask),
    .o_wr_ack(o_wr_ack), .o_rdat_vld(o_rdat_vld), .o_rdat(o_rdat),
    .o_rdat_last(o_rdat_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the array as plain bytes, addressed by line and byte.
  logic [7:0]    ref_mem [DEPTH][LINE_B];
  logic [BW-1:0] wd [BEATS];
  logic [NB-1:0] wm [BEATS];
  logic [BW-1:0] rx [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 32'(LINE_B)) % 32'(DEPTH));
  endfunction

  function automatic int off_of(input logic [AW-1:0] a);
    return int'((a / 32'(NB)) % 32'(BEATS));
  endfunction

  function automatic logic [BW-1:0] exp_beat(input logic [AW-1:0] a, input int k);
    logic [BW-1:0] r;
    int slot;
    slot = (off_of(a) + k) % BEATS;
    for (int b = 0; b < NB; b++) r[b*8 +: 8] = ref_mem[line_of(a)][slot*NB + b];
    return r;
  endfunction

  // Byte address with random bits above the index and below the beat offset.
  function automatic logic [AW-1:0] mk_addr(input int line, input int off);
    logic [AW-1:0] a;
    a = $urandom;
    a = a - (a % 32'(LINE_B * DEPTH)) + 32'(line * LINE_B + off * NB) + ($urandom % 32'(NB));
    return a;
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_rdy();
    for (int i = 0; i < 50 && !o_req_rdy; i++) step();
    check("rdy_wait", BW'(o_req_rdy), BW'(1));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int len, input int gap);
    int line, off, slot;
    wait_rdy();
    i_req_vld = 1'b1; i_req_wr = 1'b1; i_req_addr = a; i_req_len = LW'(len);
    step();
    i_req_vld = 1'b0; i_req_wr = 1'($urandom);
    for (int k = 0; k <= len; k++) begin
      for (int g = 0; g < gap; g++) begin
        i_wdat_vld = 1'b0; i_req_vld = 1'b1; i_wdat = rnd_beat(); i_wmask = '1;
        check("wr_rdy_busy", BW'(o_req_rdy), BW'(0));
        check("wr_ack_early", BW'(o_wr_ack), BW'(0));
        step();
      end
      i_req_vld = 1'($urandom); i_wdat_vld = 1'b1; i_wdat = wd[k]; i_wmask = wm[k];
      check("wr_rdy_busy", BW'(o_req_rdy), BW'(0));
      check("wr_ack_early", BW'(o_wr_ack), BW'(0));
      step();
    end
    i_wdat_vld = 1'b0; i_req_vld = 1'b0;
    check("wr_ack", BW'(o_wr_ack), BW'(1));
    check("wr_rdy_commit", BW'(o_req_rdy), BW'(0));
    line = line_of(a);
    off  = off_of(a);
    for (int k = 0; k <= len; k++) begin
      slot = (off + k) % BEATS;
      for (int b = 0; b < NB; b++)
        if (wm[k][b]) ref_mem[line][slot*NB + b] = wd[k][b*8 +: 8];
    end
    step();
    check("wr_ack_once", BW'(o_wr_ack), BW'(0));
    check("wr_rdy_back", BW'(o_req_rdy), BW'(1));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int len);
    wait_rdy();
    i_req_vld = 1'b1; i_req_wr = 1'b0; i_req_addr = a; i_req_len = LW'(len);
    step();
    i_req_vld = 1'b0;
    check("rd_vld_early", BW'(o_rdat_vld), BW'(0));
    check("rd_rdy_busy", BW'(o_req_rdy), BW'(0));
    step();
    rx.delete();
    for (int k = 0; k <= len; k++) begin
      i_req_vld = 1'($urandom); i_req_wr = 1'($urandom);
      i_wdat_vld = 1'($urandom); i_wdat = rnd_beat(); i_wmask = '1;
      check("rd_vld", BW'(o_rdat_vld), BW'(1));
      check("rd_data", o_rdat, exp_beat(a, k));
      check("rd_last", BW'(o_rdat_last), BW'(k == len));
      check("rd_rdy_busy", BW'(o_req_rdy), BW'(0));
      rx.push_back(o_rdat);
      step();
    end
    i_req_vld = 1'b0; i_wdat_vld = 1'b0;
    check("rd_rdy_back", BW'(o_req_rdy), BW'(1));
    check("rd_vld_end", BW'(o_rdat_vld), BW'(0));
  endtask

  task automatic idle_junk(input int n);
    for (int i = 0; i < n; i++) begin
      i_wdat_vld = 1'b1; i_wdat = rnd_beat(); i_wmask = '1; i_req_vld = 1'b0;
      check("idle_no_ack", BW'(o_wr_ack), BW'(0));
      step();
    end
    i_wdat_vld = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int k = 0; k < BEATS; k++) begin
      wd[k] = {NB{base + 8'(k)}};
      wm[k] = '1;
    end
  endtask

  initial begin
    logic [BW-1:0] expv;
    int len;
    rst_n = 1'b0; i_req_vld = 1'b0; i_req_wr = 1'b0; i_req_addr = '0; i_req_len = '0;
    i_wdat_vld = 1'b0; i_wdat = '0; i_wmask = '0;
    #2;
    check("rst_rdy", BW'(o_req_rdy), BW'(1));
    check("rst_ack", BW'(o_wr_ack), BW'(0));
    check("rst_vld", BW'(o_rdat_vld), BW'(0));
    check("rst_last", BW'(o_rdat_last), BW'(0));
    check("rst_rdat", o_rdat, BW'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // Give every exercised line a known value.
    for (int l = 0; l < NLINES; l++) begin
      for (int k = 0; k < BEATS; k++) begin wd[k] = rnd_beat(); wm[k] = '1; end
      do_write(mk_addr(l, 0), BEATS - 1, 0);
    end

    // Write-then-read, full line.
    fill(8'hA0);
    do_write(32'h0000_0040, 3, 0);
    do_read(32'h0000_0040, 3);
    check("full_b0", rx[0], {NB{8'hA0}});
    check("full_b3", rx[3], {NB{8'hA3}});

    // Wrapped read, critical beat first; back-to-back with the previous read.
    do_read(32'h0000_0060, 3);
    check("wrap_b0", rx[0], {NB{8'hA2}});
    check("wrap_b2", rx[2], {NB{8'hA0}});

    // Partial mask, single beat.
    wd[0] = '1; wm[0] = NB'(16'h000F);
    do_write(32'h0000_0050, 0, 0);
    do_read(32'h0000_0040, 3);
    check("pmask_b0", rx[0], {NB{8'hA0}});
    check("pmask_b1", rx[1], {{(NB-4){8'hA1}}, {4{8'hFF}}});
    check("pmask_b2", rx[2], {NB{8'hA2}});

    // Stalled write with ignored inputs, then idle-time write data.
    fill(8'h50);
    do_write(32'h0000_00C0, 3, 3);
    idle_junk(4);
    do_read(32'h0000_00C0, 3);
    check("stall_b1", rx[1], {NB{8'h51}});

    // Reset in the middle of a write: line must be untouched.
    i_req_vld = 1'b1; i_req_wr = 1'b1; i_req_addr = 32'h0000_0080; i_req_len = LW'(3);
    step();
    i_req_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_wdat_vld = 1'b1; i_wdat = {NB{8'hEE}}; i_wmask = '1;
      step();
    end
    rst_n = 1'b0;
    #1;
    check("mrst_rdy", BW'(o_req_rdy), BW'(1));
    check("mrst_ack", BW'(o_wr_ack), BW'(0));
    check("mrst_vld", BW'(o_rdat_vld), BW'(0));
    check("mrst_last", BW'(o_rdat_last), BW'(0));
    check("mrst_rdat", o_rdat, BW'(0));
    step();
    i_wdat_vld = 1'b0;
    rst_n = 1'b1;
    step();
    do_read(32'h0000_0080, 3);

    // Randomized traffic over the exercised lines.
    for (int t = 0; t < 60; t++) begin
      len = int'($urandom_range(0, BEATS - 1));
      if ($urandom % 2 == 1) begin
        for (int k = 0; k < BEATS; k++) begin
          wd[k] = rnd_beat();
          wm[k] = ($urandom % 3 == 0) ? '1 : NB'({$urandom, $urandom});
        end
        do_write(mk_addr(int'($urandom_range(0, NLINES - 1)), int'($urandom_range(0, BEATS - 1))),
                 len, int'($urandom_range(0, 2)));
      end else begin
        do_read(mk_addr(int'($urandom_range(0, NLINES - 1)), int'($urandom_range(0, BEATS - 1))),
                len);
      end
      if ($urandom % 4 == 0) idle_junk(int'($urandom_range(1, 3)));
    end

    // Final sweep of every exercised line.
    for (int l = 0; l < NLINES; l++) do_read(mk_addr(l, 0), BEATS - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Parametrised burst memory controller that sits behind the MMU's external memory port. It accepts one read or write request per transaction and moves a line of BEATS × BEAT_WIDTH bits between the beat-serial bus and an internal line-wide storage array. It supports variable burst length, critical-beat-first wrapping and per-byte write masks. Read data returns beat-serially, not line-wide.

## Interface
- BEAT_WIDTH, 128: bits per beat; power of two, ≥ 8.
- BEATS, 4: beats per line; power of two, ≥ 2.
- DEPTH, 256: lines in the storage array; power of two.
- ADDR_WIDTH, `PHY_ADDR_WIDTH: byte address width.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req_vld  in  1  request valid.
- i_req_wr  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_WIDTH  byte address; selects line index and starting beat.
- i_req_len  in  log2(BEATS)  burst length minus 1.
- o_req_rdy  out  1  controller can accept a request.
- i_wdat_vld  in  1  write beat valid.
- i_wdat  in  BEAT_WIDTH  write beat data.
- i_wmask  in  BEAT_WIDTH/8  byte enables for the write beat; 1 = write the byte.
- o_wr_ack  out  1  one-cycle pulse; the line has been committed.
- o_rdat_vld  out  1  read beat valid.
- o_rdat  out  BEAT_WIDTH  read beat data.
- o_rdat_last  out  1  final beat of the read burst.

## Operation
- Address decode:
  - Byte-in-beat bits BB = log2(BEAT_WIDTH/8); BB are ignored.
  - Beat offset = addr[BB +: log2(BEATS)].
  - Line index = addr[BB+log2(BEATS) +: log2(DEPTH)]; higher address bits are ignored.
- Beat k of a burst (k = 0..len) maps to line beat (offset + k) mod BEATS (wrap-around).
- States: IDLE, WCOLLECT, WCOMMIT, RREAD, RSEND.
- IDLE:
  - o_req_rdy = 1.
  - A handshake (i_req_vld & o_req_rdy) latches addr, len and direction, and clears the beat counter.
  - Next state is WCOLLECT for a write, RREAD for a read.
- WCOLLECT:
  - Each cycle with i_wdat_vld captures i_wdat and i_wmask into the mapped beat slot and increments the counter.
  - The capture of beat len moves to WCOMMIT.
  - Slots not written during this burst carry mask 0.
  - Cycles without i_wdat_vld stall with no timeout.
- WCOMMIT:
  - Byte-masked write of the assembled line into array[index]; bytes with mask 0 keep their old value.
  - o_wr_ack = 1; next state IDLE.
- RREAD: synchronous array read of line[index] into a line register; next state RSEND.
- RSEND:
  - Each cycle: o_rdat_vld = 1 and o_rdat = mapped beat of the line register; counter increments.
  - When counter == len: o_rdat_last = 1; next state IDLE.
  - There is no back-pressure.
- Requests presented while o_req_rdy = 0 are ignored; there is no queue.
- i_wdat_vld outside WCOLLECT is ignored.
- Reset:
  - State IDLE, counter 0.
  - o_req_rdy = 1; o_wr_ack, o_rdat_vld and o_rdat_last = 0; o_rdat = 0.
  - Array contents are not reset.
- Reset mid-burst: the transaction is abandoned. The array is unmodified unless WCOMMIT already completed.
- len = BEATS-1 with offset ≠ 0 wraps across the full line. len < BEATS-1 touches only len+1 beats.

## Timing
- Read accepted in cycle T:
  - RREAD in T+1.
  - Beats in T+2 … T+2+len.
  - o_req_rdy returns in T+3+len.
- Write:
  - The last beat is captured in cycle W.
  - WCOMMIT and the o_wr_ack pulse occur in W+1; the array is updated at the end of W+1.
  - o_req_rdy returns in W+2.
- A read accepted at W+2 returns the new data (no bypass needed).
- Minimum write occupancy is len+3 cycles including the request cycle, with a beat every cycle.
- All outputs are registered or derived from state only; no combinational path from i_* to o_*.

## Test plan
- Write-then-read, full line:
  - Stimulus: write addr 0x0000_0040, len 3, beats 0xA0…, 0xA1…, 0xA2…, 0xA3…, mask 0xFFFF; then read the same address, len 3.
  - Required: o_wr_ack one cycle after beat 3; rdat A0, A1, A2, A3; last on A3; first beat 2 cycles after the request.
- Wrapped read:
  - Stimulus: read 0x0000_0060 (offset 2), len 3, of the line above.
  - Required: beats A2, A3, A0, A1; rdy returns 6 cycles after the request.
- Partial mask, short burst:
  - Stimulus: write 0x0000_0050, len 0, data all-ones, mask 0x000F.
  - Required: reread of the line gives beat 1 with low 4 bytes 0xFF, rest of A1 unchanged; other beats unchanged.
- Stalled write and ignored inputs:
  - Stimulus: insert 3 idle cycles between beats; pulse i_req_vld and i_wdat_vld while in IDLE/RSEND.
  - Required: the line commits exactly as sent; no extra commit; o_req_rdy stays 0 during the burst.
- Back-to-back reads: the second request accepted the cycle rdy returns is serviced with identical latency.
- Reset mid-write: assert rst_n low after 2 of 4 beats. Required: outputs return to reset values; the line reads back unchanged.
